// File: rtl/core_pkg.sv
// Shared types and encodings for the load/store stage.
package core_pkg;

  // Load/store stage sequencing states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Writeback record handed to WBU (104 bits, MSB first)
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rdata;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [1:0]  rd_sel;
    logic [31:0] csr_data;
  } lsu_wb_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // WBU result source select
  localparam logic [1:0] RD_SEL_ALU  = 2'b00;
  localparam logic [1:0] RD_SEL_LOAD = 2'b01;
  localparam logic [1:0] RD_SEL_CSR  = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane replication and strobes,
// load extraction with sign/zero extension, and illegal-access detection.
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [3:0]  lane_strb_s;
  logic [31:0] shifted_s;
  logic        misalign_s;

  // Replicate store data across lanes and position the byte strobes
  always_comb begin
    wdata       = 32'h0000_0000;
    lane_strb_s = 4'b0000;
    case (funct3)
      F3_B: begin
        wdata       = {4{store_data[7:0]}};
        lane_strb_s = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata       = {2{store_data[15:0]}};
        lane_strb_s = 4'b0011 << addr_lo;
      end
      F3_W: begin
        wdata       = store_data;
        lane_strb_s = 4'b1111;
      end
      default: begin
        wdata       = 32'h0000_0000;
        lane_strb_s = 4'b0000;
      end
    endcase
  end

  // Reads never assert strobes
  always_comb begin
    wstrb = 4'b0000;
    if (wen) begin
      wstrb = lane_strb_s;
    end else begin
      wstrb = 4'b0000;
    end
  end

  assign shifted_s = rdata >> {addr_lo, 3'b000};

  // Extract the addressed lane and extend to full width
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    load_data = shifted_s;
      F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Alignment check per access size; reserved encodings count as illegal
  always_comb begin
    misalign_s = 1'b0;
    case (funct3)
      F3_B, F3_BU: misalign_s = 1'b0;
      F3_H, F3_HU: misalign_s = addr_lo[0];
      F3_W:        misalign_s = (addr_lo != 2'b00);
      default:     misalign_s = 1'b1;
    endcase
  end

  // Only memory operations can fault; stores have no unsigned variants
  always_comb begin
    fault = 1'b0;
    if (ren || wen) begin
      fault = misalign_s | (ren & wen) | (wen & funct3[2]);
    end else begin
      fault = 1'b0;
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WBU: one memory transaction per
// accepted instruction, then a single-cycle writeback record pulse.
module lsu_stage
  import core_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [WIDTH-1:0]  exu_alu_result,
  input  logic [WIDTH-1:0]  exu_store_data,
  input  logic              exu_mem_ren,
  input  logic              exu_mem_wen,
  input  logic [2:0]        exu_funct3,
  input  logic              exu_rd_wen,
  input  logic [4:0]        exu_rd_addr,
  input  logic [1:0]        exu_rd_sel,
  input  logic [WIDTH-1:0]  exu_csr_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [WIDTH-1:0]  mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [WIDTH-1:0]  mem_resp_rdata,
  input  logic              mem_resp_err,
  output logic              lsu_valid,
  output logic [103:0]      lsu_data,
  output logic              lsu_fault
);

  lsu_state_e state_r, next_state_s;

  logic [WIDTH-1:0]  alu_r, csr_r;
  logic [2:0]        f3_r;
  logic              ren_r, wen_r, rd_wen_r;
  logic [4:0]        rd_addr_r;
  logic [1:0]        rd_sel_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [WIDTH-1:0]  req_wdata_r;
  logic [3:0]        req_wstrb_r;
  logic              exu_ready_r, req_valid_r, resp_ready_r, lsu_valid_r, lsu_fault_r;
  lsu_wb_t           lsu_data_r, wb_next_s;
  logic              fault_next_s;

  logic              idle_s, accept_s;
  logic [1:0]        al_addr_s;
  logic [2:0]        al_f3_s;
  logic              al_ren_s, al_wen_s;
  logic [31:0]       al_wdata_s, al_load_s;
  logic [3:0]        al_wstrb_s;
  logic              al_fault_s;

  assign idle_s   = (state_r == LSU_IDLE);
  assign accept_s = exu_valid & idle_s;

  // In IDLE the aligner looks at the incoming EXU fields; afterwards at the latched copy
  assign al_addr_s = idle_s ? exu_alu_result[1:0] : alu_r[1:0];
  assign al_f3_s   = idle_s ? exu_funct3  : f3_r;
  assign al_ren_s  = idle_s ? exu_mem_ren : ren_r;
  assign al_wen_s  = idle_s ? exu_mem_wen : wen_r;

  lsu_align u_align (
    .addr_lo    (al_addr_s),
    .funct3     (al_f3_s),
    .ren        (al_ren_s),
    .wen        (al_wen_s),
    .store_data (exu_store_data),
    .rdata      (mem_resp_rdata),
    .wdata      (al_wdata_s),
    .wstrb      (al_wstrb_s),
    .load_data  (al_load_s),
    .fault      (al_fault_s)
  );

  // Next-state sequencing; faulted or non-memory work skips the bus entirely
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (exu_valid) begin
          if (!(exu_mem_ren || exu_mem_wen) || al_fault_s) begin
            next_state_s = LSU_DONE;
          end else begin
            next_state_s = LSU_REQ;
          end
        end else begin
          next_state_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          next_state_s = LSU_RESP;
        end else begin
          next_state_s = LSU_REQ;
        end
      end
      LSU_RESP: begin
        if (mem_resp_valid) begin
          next_state_s = LSU_DONE;
        end else begin
          next_state_s = LSU_RESP;
        end
      end
      LSU_DONE: next_state_s = LSU_IDLE;
      default:  next_state_s = LSU_IDLE;
    endcase
  end

  // Build the writeback record for the cycle that enters DONE
  always_comb begin
    wb_next_s    = '0;
    fault_next_s = 1'b0;
    if (idle_s) begin
      wb_next_s.alu_result = exu_alu_result;
      wb_next_s.rdata      = 32'h0000_0000;
      wb_next_s.rd_wen     = exu_rd_wen & ~al_fault_s;
      wb_next_s.rd_addr    = exu_rd_addr;
      wb_next_s.rd_sel     = exu_rd_sel;
      wb_next_s.csr_data   = exu_csr_data;
      fault_next_s         = al_fault_s;
    end else begin
      wb_next_s.alu_result = alu_r;
      wb_next_s.rdata      = (ren_r && !mem_resp_err) ? al_load_s : 32'h0000_0000;
      wb_next_s.rd_wen     = rd_wen_r & ~mem_resp_err;
      wb_next_s.rd_addr    = rd_addr_r;
      wb_next_s.rd_sel     = rd_sel_r;
      wb_next_s.csr_data   = csr_r;
      fault_next_s         = mem_resp_err;
    end
  end

  // State register and registered handshake outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= LSU_IDLE;
      exu_ready_r  <= 1'b1;
      req_valid_r  <= 1'b0;
      resp_ready_r <= 1'b0;
      lsu_valid_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      exu_ready_r  <= (next_state_s == LSU_IDLE);
      req_valid_r  <= (next_state_s == LSU_REQ);
      resp_ready_r <= (next_state_s == LSU_RESP);
      lsu_valid_r  <= (next_state_s == LSU_DONE);
    end
  end

  // Capture the EXU result and the bus request image on accept; held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_r       <= '0;
      csr_r       <= '0;
      f3_r        <= 3'b000;
      ren_r       <= 1'b0;
      wen_r       <= 1'b0;
      rd_wen_r    <= 1'b0;
      rd_addr_r   <= 5'd0;
      rd_sel_r    <= 2'b00;
      req_addr_r  <= '0;
      req_wdata_r <= '0;
      req_wstrb_r <= 4'b0000;
    end else if (accept_s) begin
      alu_r       <= exu_alu_result;
      csr_r       <= exu_csr_data;
      f3_r        <= exu_funct3;
      ren_r       <= exu_mem_ren;
      wen_r       <= exu_mem_wen;
      rd_wen_r    <= exu_rd_wen;
      rd_addr_r   <= exu_rd_addr;
      rd_sel_r    <= exu_rd_sel;
      req_addr_r  <= {exu_alu_result[ADDR_W-1:2], 2'b00};
      req_wdata_r <= al_wdata_s;
      req_wstrb_r <= al_wstrb_s;
    end
  end

  // Writeback record and fault flag, updated only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_data_r  <= '0;
      lsu_fault_r <= 1'b0;
    end else if (next_state_s == LSU_DONE) begin
      lsu_data_r  <= wb_next_s;
      lsu_fault_r <= fault_next_s;
    end
  end

  assign exu_ready      = exu_ready_r;
  assign mem_req_valid  = req_valid_r;
  assign mem_req_addr   = req_addr_r;
  assign mem_req_wen    = wen_r;
  assign mem_req_wdata  = req_wdata_r;
  assign mem_req_wstrb  = req_wstrb_r;
  assign mem_resp_ready = resp_ready_r;
  assign lsu_valid      = lsu_valid_r;
  assign lsu_data       = lsu_data_r;
  assign lsu_fault      = lsu_fault_r;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with a scoreboard of expected writeback records.
module tb_lsu_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         exu_valid, exu_ready;
  logic [31:0]  exu_alu_result, exu_store_data, exu_csr_data;
  logic         exu_mem_ren, exu_mem_wen, exu_rd_wen;
  logic [2:0]   exu_funct3;
  logic [4:0]   exu_rd_addr;
  logic [1:0]   exu_rd_sel;
  logic         mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0]  mem_req_addr, mem_req_wdata;
  logic [3:0]   mem_req_wstrb;
  logic         mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0]  mem_resp_rdata;
  logic         lsu_valid, lsu_fault;
  logic [103:0] lsu_data;

  typedef struct packed {
    logic [103:0] data;
    logic         fault;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  logic   prev_valid = 1'b0;
  int     checks = 0;
  int     errors = 0;
  logic [103:0] last_rec;

  lsu_stage dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready),
    .exu_alu_result(exu_alu_result), .exu_store_data(exu_store_data),
    .exu_mem_ren(exu_mem_ren), .exu_mem_wen(exu_mem_wen), .exu_funct3(exu_funct3),
    .exu_rd_wen(exu_rd_wen), .exu_rd_addr(exu_rd_addr), .exu_rd_sel(exu_rd_sel),
    .exu_csr_data(exu_csr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .lsu_valid(lsu_valid), .lsu_data(lsu_data), .lsu_fault(lsu_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] mk(input logic [31:0] alu, input logic [31:0] rd,
                                      input logic wen, input logic [4:0] ra,
                                      input logic [1:0] sel, input logic [31:0] csr);
    return {alu, rd, wen, ra, sel, csr};
  endfunction

  task automatic expect_rec(input logic [103:0] d, input logic f);
    exp_t e;
    e.data  = d;
    e.fault = f;
    exp_q.push_back(e);
    last_rec = d;
  endtask

  // Drive one EXU result at a negedge; it is accepted on the following posedge
  task automatic do_accept(input logic [31:0] alu, input logic [31:0] sd, input logic ren,
                           input logic wen, input logic [2:0] f3, input logic rdw,
                           input logic [4:0] ra, input logic [1:0] sel, input logic [31:0] csr);
    int n;
    n = 0;
    @(negedge clk);
    while (!exu_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("exu_ready_wait", {103'd0, exu_ready}, 104'd1);
    exu_alu_result = alu; exu_store_data = sd; exu_mem_ren = ren; exu_mem_wen = wen;
    exu_funct3 = f3; exu_rd_wen = rdw; exu_rd_addr = ra; exu_rd_sel = sel; exu_csr_data = csr;
    exu_valid = 1'b1;
    @(posedge clk);
    #1 exu_valid = 1'b0;
  endtask

  // Serve one bus transaction: stall the request, check it stays put, then respond
  task automatic mem_cycle(input int stall, input logic [31:0] rdata, input logic err,
                           input logic [31:0] ea, input logic [31:0] ewd,
                           input logic [3:0] ews, input logic ewen);
    int n;
    logic [103:0] req_exp;
    req_exp = {35'd0, ea, ewd, ews, ewen};
    n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_valid_wait", {103'd0, mem_req_valid}, 104'd1);
    for (int i = 0; i < stall; i++) begin
      check("req_stall_fields", {35'd0, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen}, req_exp);
      check("req_stall_valid", {103'd0, mem_req_valid}, 104'd1);
      @(negedge clk);
    end
    check("req_fields", {35'd0, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen}, req_exp);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    check("resp_ready", {102'd0, mem_resp_ready, mem_req_valid}, 104'd2);
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = err;
    @(posedge clk);
    #1 begin mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_rdata = 32'h0; end
    @(negedge clk);
    check("mem_done_valid", {103'd0, lsu_valid}, 104'd1);
  endtask

  // Scoreboard: every lsu_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (lsu_valid) begin
        check("valid_pulse_width", {103'd0, prev_valid}, 104'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {103'd0, lsu_valid}, 104'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_data", lsu_data, mon_e.data);
          check("wb_fault", {103'd0, lsu_fault}, {103'd0, mon_e.fault});
        end
      end
      prev_valid = lsu_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; exu_valid = 1'b0; exu_alu_result = 32'h0; exu_store_data = 32'h0;
    exu_mem_ren = 1'b0; exu_mem_wen = 1'b0; exu_funct3 = 3'b000; exu_rd_wen = 1'b0;
    exu_rd_addr = 5'd0; exu_rd_sel = 2'b00; exu_csr_data = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
    last_rec = 104'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {99'd0, exu_ready, lsu_valid, lsu_fault, mem_req_valid, mem_resp_ready}, 104'h10);
    check("reset_data", lsu_data, 104'd0);
    rst_n = 1'b1;

    // Non-memory pass-through, one cycle latency
    expect_rec(mk(32'h12345678, 32'h0, 1'b1, 5'd5, 2'b00, 32'hCAFE0001), 1'b0);
    do_accept(32'h12345678, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 2'b00, 32'hCAFE0001);
    @(negedge clk);
    check("nm_latency", {102'd0, lsu_valid, mem_req_valid}, 104'd2);
    @(negedge clk);
    check("nm_after", {102'd0, lsu_valid, exu_ready}, 104'd1);

    // LB / LBU from the top byte lane
    expect_rec(mk(32'h80000003, 32'hFFFFFF80, 1'b1, 5'd7, 2'b01, 32'h0), 1'b0);
    do_accept(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7, 2'b01, 32'h0);
    mem_cycle(0, 32'h80ABCDEF, 1'b0, 32'h80000000, 32'h0, 4'b0000, 1'b0);
    expect_rec(mk(32'h80000003, 32'h00000080, 1'b1, 5'd8, 2'b01, 32'h0), 1'b0);
    do_accept(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b100, 1'b1, 5'd8, 2'b01, 32'h0);
    mem_cycle(1, 32'h80ABCDEF, 1'b0, 32'h80000000, 32'h0, 4'b0000, 1'b0);

    // LH upper half, sign-extended
    expect_rec(mk(32'h80000002, 32'hFFFF8001, 1'b1, 5'd9, 2'b01, 32'h0), 1'b0);
    do_accept(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 5'd9, 2'b01, 32'h0);
    mem_cycle(0, 32'h80011234, 1'b0, 32'h80000000, 32'h0, 4'b0000, 1'b0);

    // SH with a 3-cycle request stall
    expect_rec(mk(32'h80000002, 32'h0, 1'b0, 5'd0, 2'b00, 32'h0), 1'b0);
    do_accept(32'h80000002, 32'hDEADBEEF, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 2'b00, 32'h0);
    mem_cycle(3, 32'h0, 1'b0, 32'h80000000, 32'hBEEFBEEF, 4'b1100, 1'b1);
    repeat (2) @(negedge clk);
    check("data_held", lsu_data, last_rec);
    check("valid_low_held", {103'd0, lsu_valid}, 104'd0);

    // SB to byte lane 1
    expect_rec(mk(32'h80000101, 32'h0, 1'b0, 5'd0, 2'b00, 32'h0), 1'b0);
    do_accept(32'h80000101, 32'h123456A5, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 2'b00, 32'h0);
    mem_cycle(0, 32'h0, 1'b0, 32'h80000100, 32'hA5A5A5A5, 4'b0010, 1'b1);

    // Misaligned LW: fault without a bus transaction
    expect_rec(mk(32'h80000001, 32'h0, 1'b0, 5'd3, 2'b01, 32'h5), 1'b1);
    do_accept(32'h80000001, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd3, 2'b01, 32'h5);
    @(negedge clk);
    check("misalign_lw", {101'd0, lsu_valid, lsu_fault, mem_req_valid}, 104'd6);

    // Reserved load funct3 and simultaneous ren/wen both fault immediately
    expect_rec(mk(32'h80000000, 32'h0, 1'b0, 5'd4, 2'b01, 32'h0), 1'b1);
    do_accept(32'h80000000, 32'h0, 1'b1, 1'b0, 3'b011, 1'b1, 5'd4, 2'b01, 32'h0);
    @(negedge clk);
    check("reserved_f3", {101'd0, lsu_valid, lsu_fault, mem_req_valid}, 104'd6);
    expect_rec(mk(32'h80000000, 32'h0, 1'b0, 5'd6, 2'b01, 32'h0), 1'b1);
    do_accept(32'h80000000, 32'h1, 1'b1, 1'b1, 3'b010, 1'b1, 5'd6, 2'b01, 32'h0);
    @(negedge clk);
    check("ren_wen_both", {101'd0, lsu_valid, lsu_fault, mem_req_valid}, 104'd6);

    // LW with bus error
    expect_rec(mk(32'h80000010, 32'h0, 1'b0, 5'd10, 2'b01, 32'h0), 1'b1);
    do_accept(32'h80000010, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd10, 2'b01, 32'h0);
    mem_cycle(0, 32'h11223344, 1'b1, 32'h80000010, 32'h0, 4'b0000, 1'b0);

    // Reset while waiting for a response; later stray response must be ignored
    do_accept(32'h80000020, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd11, 2'b01, 32'h0);
    @(negedge clk);
    check("rst_req_seen", {103'd0, mem_req_valid}, 104'd1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    check("rst_in_resp", {103'd0, mem_resp_ready}, 104'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_drop", {100'd0, lsu_valid, mem_req_valid, mem_resp_ready, exu_ready}, 104'd1);
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stray1", {101'd0, lsu_valid, mem_resp_ready, exu_ready}, 104'd1);
    @(negedge clk);
    check("rst_stray2", {101'd0, lsu_valid, mem_resp_ready, exu_ready}, 104'd1);
    mem_resp_valid = 1'b0;

    // Recovery with an ordinary pass-through
    expect_rec(mk(32'hA5A50F0F, 32'h0, 1'b1, 5'd31, 2'b10, 32'h00000777), 1'b0);
    do_accept(32'hA5A50F0F, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd31, 2'b10, 32'h00000777);
    @(negedge clk);
    check("recover_valid", {103'd0, lsu_valid}, 104'd1);
    repeat (3) @(negedge clk);
    check("queue_drained", 104'(exp_q.size()), 104'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
